uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NREQ byte requesters.
- Round-robin arbitration; the winner's byte is latched and presented on txDataOUT.
- Sequences the transmitter handshake: assert sendOUT, wait for nBusyIN low (accepted), then wait for nBusyIN high (done).
- Returns a one-cycle ackOUT to the winner. Sits between the command/message sources and the UART TX core.

---
 rtl/uart_tx_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte requesters.
// The winner's byte is latched and the send/busy handshake is sequenced:
// SEND until nBusyIN drops, WAIT until it rises, DONE pulses ackOUT to the owner.
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a SEND that the
// transmitter never accepts within TIMEOUT cycles (errOUT pulse, no ack).
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clkIN,
    input  logic               resetIN,
    input  logic [NREQ-1:0]    reqIN,
    input  logic [NREQ*DW-1:0] dataIN,
    input  logic               nBusyIN,
    output logic               sendOUT,
    output logic [DW-1:0]      txDataOUT,
    output logic [NREQ-1:0]    grantOUT,
    output logic [NREQ-1:0]    ackOUT,
    output logic               activeOUT,
    output logic               errOUT
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              send_q, send_d;
    logic [DW-1:0]     tx_q, tx_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              active_q, active_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;

    logic [NREQ-1:0]   upper_req;
    logic [NREQ-1:0]   pick_req;
    logic [NREQ-1:0]   win_oh;
    logic [PW-1:0]     win_idx;
    logic [DW-1:0]     win_data;
    logic [PW-1:0]     next_ptr;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall (wrap).
    always_comb begin
        upper_req = '0;
        pick_req  = '0;
        win_oh    = '0;
        win_idx   = '0;
        win_data  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            upper_req[i] = reqIN[i] & (PW'(i) >= ptr_q);
        end
        pick_req = (|upper_req) ? upper_req : reqIN;
        // Descending scan so the lowest set index is the last one written.
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (pick_req[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_idx   = PW'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_oh[i]) begin
                win_data = dataIN[i*DW +: DW];
            end
        end
    end

    // Pointer moves to the slot just past the owner once its transfer ends.
    always_comb begin
        next_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
    end

    // FSM next-state and registered-output values.
    always_comb begin
        state_d  = state_q;
        send_d   = send_q;
        tx_d     = tx_q;
        grant_d  = grant_q;
        ack_d    = '0;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                // A busy transmitter blocks new grants even with requests pending.
                if ((|reqIN) && nBusyIN) begin
                    tx_d    = win_data;
                    grant_d = win_oh;
                    owner_d = win_idx;
                    send_d  = 1'b1;
                    state_d = StSend;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StSend: begin
                if (!nBusyIN) begin
                    send_d  = 1'b0;
                    state_d = StWait;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    send_d  = 1'b0;
                    grant_d = '0;
                    err_d   = 1'b1;
                    ptr_d   = next_ptr;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            StWait: begin
                if (nBusyIN) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        active_d = (state_d != StIdle);
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            state_q  <= StIdle;
            send_q   <= 1'b0;
            tx_q     <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            active_q <= 1'b0;
            ptr_q    <= '0;
            owner_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            send_q   <= send_d;
            tx_q     <= tx_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            active_q <= active_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign sendOUT   = send_q;
    assign txDataOUT = tx_q;
    assign grantOUT  = grant_q;
    assign ackOUT    = ack_q;
    assign activeOUT = active_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign errOUT    = err_q;
`else
    assign errOUT    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus hand-written
// multi-cycle sequences; acks are checked against a scoreboard queue.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1024;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] data;
    logic              nbusy;
    logic              send;
    logic [DW-1:0]     txd;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic              active;
    logic              err;

    logic              model_nbusy;
    logic              force_busy;
    logic              tx_en;
    logic              err_seen;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [DW-1:0]   tx;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*DW-1:0] data;
        logic [NREQ-1:0]    ack;
        logic [DW-1:0]      tx;
    } vec_t;
    vec_t vecs[5];

    assign nbusy = force_busy ? 1'b0 : model_nbusy;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clkIN     (clk),
        .resetIN   (rst),
        .reqIN     (req),
        .dataIN    (data),
        .nBusyIN   (nbusy),
        .sendOUT   (send),
        .txDataOUT (txd),
        .grantOUT  (grant),
        .ackOUT    (ack),
        .activeOUT (active),
        .errOUT    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [NREQ-1:0] a, input logic [DW-1:0] t);
        exp_t e;
        e.ack = a;
        e.tx  = t;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_send"},   {31'b0, send},   0);
        check({tag, "_txdata"}, {24'b0, txd},    0);
        check({tag, "_grant"},  {28'b0, grant},  0);
        check({tag, "_ack"},    {28'b0, ack},    0);
        check({tag, "_active"}, {31'b0, active}, 0);
        check({tag, "_err"},    {31'b0, err},    0);
    endtask

    // Returns at the first negedge on which an ack is visible (bounded).
    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < 200);
        if (ack == '0) check("ack_wait_timeout", 0, 1);
    endtask

    task automatic wait_busy_low();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (nbusy && n < 50);
        if (nbusy) check("busy_wait_timeout", 0, 1);
    endtask

    // Transmitter model: accepts 3 cycles after seeing sendOUT, busy for 10 cycles.
    initial begin
        model_nbusy = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_en && send && !rst) begin
                repeat (3) @(negedge clk);
                model_nbusy = 1'b0;
                repeat (10) @(negedge clk);
                model_nbusy = 1'b1;
            end
        end
    end

    // Output monitor: one-hot invariants and scoreboard comparison on every ack.
    initial begin
        exp_t e;
        err_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (err) err_seen = 1'b1;
            if (!$onehot0(grant) || !$onehot0(ack)) check("onehot", {24'b0, grant, ack}, 0);
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", {28'b0, ack}, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_owner",  {28'b0, ack}, {28'b0, e.ack});
                    check("ack_txdata", {24'b0, txd}, {24'b0, e.tx});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Pointer starts at 0 after reset; each entry advances it past its owner.
        vecs[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5}; // ptr -> 3
        vecs[1] = '{4'b0011, 32'hDEAD_BEEF, 4'b0001, 8'hEF}; // wrap from 3 -> 0
        vecs[2] = '{4'b1001, 32'h1234_5678, 4'b1000, 8'h12}; // from 1 -> 3
        vecs[3] = '{4'b0110, 32'hCAFE_F00D, 4'b0010, 8'hF0}; // from 0 -> 1
        vecs[4] = '{4'b0011, 32'h0000_5A3C, 4'b0001, 8'h3C}; // from 2 wraps -> 0

        rst        = 1'b1;
        req        = '0;
        data       = '0;
        force_busy = 1'b0;
        tx_en      = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Table-driven single transfers.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            req  = vecs[v].req;
            data = vecs[v].data;
            push_exp(vecs[v].ack, vecs[v].tx);
            @(negedge clk);
            check("vec_send_rise", {31'b0, send},   1);
            check("vec_grant",     {28'b0, grant},  {28'b0, vecs[v].ack});
            check("vec_txdata",    {24'b0, txd},    {24'b0, vecs[v].tx});
            check("vec_active",    {31'b0, active}, 1);
            wait_ack();
            req = '0;
            @(negedge clk);
            check("vec_active_low", {31'b0, active}, 0);
        end

        // Round-robin with all requesters held: 0,1,2,3,0 from a reset pointer.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req  = 4'b1111;
        data = 32'h1312_1110;
        push_exp(4'b0001, 8'h10);
        push_exp(4'b0010, 8'h11);
        push_exp(4'b0100, 8'h12);
        push_exp(4'b1000, 8'h13);
        push_exp(4'b0001, 8'h10);
        for (int k = 0; k < 5; k++) wait_ack();
        req = '0;
        @(negedge clk);

        // Transmitter busy while idle: no grant until nBusyIN returns high.
        @(negedge clk);
        force_busy = 1'b1;
        req        = 4'b0001;
        data       = 32'h0000_00C3;
        repeat (4) begin
            @(negedge clk);
            check("busy_no_send",  {31'b0, send},  0);
            check("busy_no_grant", {28'b0, grant}, 0);
        end
        force_busy = 1'b0;
        push_exp(4'b0001, 8'hC3);
        @(negedge clk);
        check("busy_release_send",  {31'b0, send},  1);
        check("busy_release_grant", {28'b0, grant}, 4'b0001);
        wait_ack();
        req = '0;
        @(negedge clk);

        // Owner changes its byte and drops its request mid-transfer.
        @(negedge clk);
        req  = 4'b0010;
        data = 32'h0000_3300;
        push_exp(4'b0010, 8'h33);
        wait_busy_low();
        data = 32'h0000_4400;
        req  = '0;
        @(negedge clk);
        check("hold_txdata", {24'b0, txd},   8'h33);
        check("hold_grant",  {28'b0, grant}, 4'b0010);
        wait_ack();
        @(negedge clk);

        // Async reset during WAIT: outputs clear before the next edge, no ack.
        @(negedge clk);
        req  = 4'b0100;
        data = 32'h0077_0000;
        wait_busy_low();
        req = '0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        sb.delete();
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Pointer was 2 before reset; from 0 slot 1 must beat slot 3.
        req  = 4'b1010;
        data = 32'h5500_6600;
        push_exp(4'b0010, 8'h66);
        @(negedge clk);
        check("post_reset_grant", {28'b0, grant}, 4'b0010);
        wait_ack();
        req = '0;
        @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
        // Transmitter never accepts: abort after TIMEOUT cycles, next requester granted.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tx_en = 1'b0;
        req   = 4'b0011;
        data  = 32'h0000_BBAA;
        @(negedge clk);
        n = 0;
        while (send && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("to_send_cycles", n, 16);
        check("to_err_pulse",   {31'b0, err},   1);
        check("to_no_ack",      {28'b0, ack},   0);
        check("to_grant_clear", {28'b0, grant}, 0);
        tx_en = 1'b1;
        push_exp(4'b0010, 8'hBB);
        @(negedge clk);
        check("to_next_grant", {28'b0, grant}, 4'b0010);
        check("to_err_clear",  {31'b0, err},   0);
        req = '0;
        wait_ack();
        @(negedge clk);
`else
        check("err_never", {31'b0, err_seen}, 0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
